// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Brief    : Writer-side bus of the UART transmit FIFO: byte write strobe,
//             overrun clear and FIFO/serializer status.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic [7:0] tx_wdata;
    logic       tx_wten;
    logic       tx_err_clr;
    logic       tx_fifo_full;
    logic       tx_fifo_overrun;
    logic       tx_fifo_underrun;
    logic       tx_busy;

    // Byte producer side
    modport master (
        output tx_wdata,
        output tx_wten,
        output tx_err_clr,
        input  tx_fifo_full,
        input  tx_fifo_overrun,
        input  tx_fifo_underrun,
        input  tx_busy
    );

    // Transmitter side
    modport slave (
        input  tx_wdata,
        input  tx_wten,
        input  tx_err_clr,
        output tx_fifo_full,
        output tx_fifo_overrun,
        output tx_fifo_underrun,
        output tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Byte FIFO feeding an 8N1 UART serializer (LSB first, fixed
//             BAUD_DIV clocks per bit). Optional macro UART_TX_PARITY_EN adds
//             an even-parity bit between the data bits and the stop bit (8E1).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int BAUD_DIV = 208,
    parameter int FIFO_AW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus,
    output logic           uart_tx
);

    localparam int               c_DEPTH     = 1 << FIFO_AW;
    localparam int               c_BW        = $clog2(BAUD_DIV);
    localparam logic [FIFO_AW:0] c_FULL_CNT  = (FIFO_AW+1)'(c_DEPTH);
    localparam logic [c_BW-1:0]  c_BAUD_LAST = c_BW'(BAUD_DIV - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    // FIFO state
    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_count_nxt;
    logic               r_overrun;
    logic               r_busy;

    // Serializer state
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_BW-1:0]    r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               w_tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_baud_end;

    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write
    assign w_full     = (r_count == c_FULL_CNT);
    assign w_push     = bus.tx_wten & ~w_full;
    assign w_pop      = (r_state == c_IDLE) && (r_count != '0);
    assign w_baud_end = (r_baud == c_BAUD_LAST);

    assign bus.tx_fifo_full     = w_full;
    assign bus.tx_fifo_overrun  = r_overrun;
    assign bus.tx_fifo_underrun = 1'b0;
    assign bus.tx_busy          = r_busy;
    assign uart_tx              = r_tx;

    // FIFO storage: no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.tx_wdata;
        end
    end

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, count, sticky overrun (set beats clear) and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (bus.tx_wten && w_full) begin
                r_overrun <= 1'b1;
            end else if (bus.tx_err_clr) begin
                r_overrun <= 1'b0;
            end
            r_busy <= (w_state_nxt != c_IDLE) || (w_count_nxt != '0);
        end
    end

    // Serializer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serializer next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_pop)      w_state_nxt = c_START;
            c_START: if (w_baud_end) w_state_nxt = c_DATA;
            c_DATA: begin
                if (w_baud_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = c_PARITY;
`else
                    w_state_nxt = c_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: if (w_baud_end) w_state_nxt = c_STOP;
`endif
            c_STOP:  if (w_baud_end) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Line level for the current state; registered below so the pin is glitch-free
    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            c_IDLE:   w_tx_nxt = 1'b1;
            c_START:  w_tx_nxt = 1'b0;
            c_DATA:   w_tx_nxt = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_PARITY: w_tx_nxt = r_par;
`endif
            c_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Baud counter, bit index, shift register and the registered TX pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_tx <= w_tx_nxt;
            if (r_state == c_IDLE) begin
                r_baud <= '0;
                r_bit  <= 3'd0;
                if (w_pop) begin
                    r_shift <= r_mem[r_rptr];
                end
            end else if (w_baud_end) begin
                r_baud <= '0;
                if (r_state == c_DATA) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte, captured as it is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= ^r_mem[r_rptr];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed self-checking bench for uart_tx_fifo (BAUD_DIV=4,
//             FIFO_AW=2). Honours UART_TX_PARITY_EN for the 8E1 frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int B  = 4;
    localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FL  = SLOTS * B;   // frame length in clocks
    localparam int PER = FL + 1;      // frame plus the single idle cycle

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx;

    int errors = 0;
    int checks = 0;
    logic rx [0:511];

    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .BAUD_DIV (B),
        .FIFO_AW  (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    // Expected line level at sample k (0 = first start-bit cycle) of a frame
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int slot;
        slot = k / B;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic drive_idle();
        bus.tx_wdata   = 8'h00;
        bus.tx_wten    = 1'b0;
        bus.tx_err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_tx, bus.tx_fifo_full, bus.tx_fifo_overrun, bus.tx_fifo_underrun, bus.tx_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_values: got tx/full/ovr/udr/busy=%b expected 10000",
                     {uart_tx, bus.tx_fifo_full, bus.tx_fifo_overrun, bus.tx_fifo_underrun, bus.tx_busy});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({uart_tx, bus.tx_busy} !== 2'b10) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got tx/busy=%b expected 10", i, {uart_tx, bus.tx_busy});
            end
        end
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        bus.tx_wdata = 8'hA5;
        bus.tx_wten  = 1'b1;
        @(negedge clk);                      // edge N has taken the write
        drive_idle();
        checks++;
        if ({uart_tx, bus.tx_busy} !== 2'b11) begin
            errors++;
            $display("FAIL single_after_write: got tx/busy=%b expected 11", {uart_tx, bus.tx_busy});
        end
        @(negedge clk);                      // after N+1: line still high
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got tx=%b expected 1 after N+1", uart_tx);
        end
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            checks++;
            if (uart_tx !== exp_bit(8'hA5, k)) begin
                errors++;
                $display("FAIL single_frame sample %0d: got %b expected %b", k, uart_tx, exp_bit(8'hA5, k));
            end
            if (k == FL - 2) begin
                checks++;
                if (bus.tx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy_stop: got %b expected 1", bus.tx_busy);
                end
            end
            if (k == FL - 1) begin
                checks++;
                if (bus.tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_drop: got %b expected 0", bus.tx_busy);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL single_post_idle: got tx=%b expected 1", uart_tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1;
        @(negedge clk);
        bus.tx_wdata = 8'h55;
        bus.tx_wten  = 1'b1;
        @(negedge clk);
        bus.tx_wdata = 8'h0F;
        @(negedge clk);                      // after N+1
        drive_idle();
        for (int k = 0; k <= 2 * FL; k++) begin
            @(negedge clk);
            rx[k] = uart_tx;
        end
        d0 = 8'h00;
        d1 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d0[i] = rx[B + B*i + B/2];
            d1[i] = rx[PER + B + B*i + B/2];
        end
        checks++;
        if (d0 !== 8'h55) begin
            errors++;
            $display("FAIL b2b_byte0: got %h expected 55", d0);
        end
        checks++;
        if (d1 !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_byte1: got %h expected 0f", d1);
        end
        checks++;
        if ({rx[0], rx[FL-1], rx[FL], rx[FL+1]} !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_gap: got start0/stop0/gap/start1=%b expected 0110",
                     {rx[0], rx[FL-1], rx[FL], rx[FL+1]});
        end
    endtask

    task automatic test_full_overrun();
        int t_end;
        logic [7:0] d;
        t_end = 3 + PER*4 + FL + 2;
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            rx[t] = uart_tx;
            if (t == 4) begin
                checks++;
                if (bus.tx_fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_not_full_yet: got %b expected 0", bus.tx_fifo_full);
                end
            end
            if (t == 5) begin
                checks++;
                if ({bus.tx_fifo_full, bus.tx_fifo_overrun} !== 2'b10) begin
                    errors++;
                    $display("FAIL ovr_full: got full/ovr=%b expected 10", {bus.tx_fifo_full, bus.tx_fifo_overrun});
                end
            end
            if (t == 6) begin
                checks++;
                if ({bus.tx_fifo_full, bus.tx_fifo_overrun} !== 2'b11) begin
                    errors++;
                    $display("FAIL ovr_set: got full/ovr=%b expected 11", {bus.tx_fifo_full, bus.tx_fifo_overrun});
                end
            end
            if (t == 7) begin
                checks++;
                if (bus.tx_fifo_overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_clear: got %b expected 0", bus.tx_fifo_overrun);
                end
            end
            if (t == 8) begin
                checks++;
                if (bus.tx_fifo_overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_set_wins: got %b expected 1", bus.tx_fifo_overrun);
                end
            end
            if (t == t_end) begin
                checks++;
                if ({uart_tx, bus.tx_busy, bus.tx_fifo_underrun} !== 3'b100) begin
                    errors++;
                    $display("FAIL ovr_drain: got tx/busy/udr=%b expected 100",
                             {uart_tx, bus.tx_busy, bus.tx_fifo_underrun});
                end
            end
            // inputs for the following edge
            drive_idle();
            if (t <= 5) begin
                bus.tx_wdata = 8'(t + 1);
                bus.tx_wten  = 1'b1;
            end else if (t == 6) begin
                bus.tx_err_clr = 1'b1;
            end else if (t == 7) begin
                bus.tx_wdata   = 8'h77;
                bus.tx_wten    = 1'b1;
                bus.tx_err_clr = 1'b1;
            end
        end
        for (int j = 0; j < 5; j++) begin
            d = 8'h00;
            for (int i = 0; i < 8; i++) begin
                d[i] = rx[3 + PER*j + B + B*i + B/2];
            end
            checks++;
            if (d !== 8'(j + 1)) begin
                errors++;
                $display("FAIL ovr_wire_byte%0d: got %h expected %h", j, d, 8'(j + 1));
            end
        end
        bus.tx_err_clr = 1'b1;
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.tx_fifo_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_final_clear: got %b expected 0", bus.tx_fifo_overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        bus.tx_wdata = 8'h00;
        bus.tx_wten  = 1'b1;
        @(negedge clk);
        @(negedge clk);                      // second 0x00 stays queued
        drive_idle();
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);                  // ends in the middle of data bit 3
        end
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: got tx=%b expected 0", uart_tx);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({uart_tx, bus.tx_busy, bus.tx_fifo_full} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_async: got tx/busy/full=%b expected 100",
                     {uart_tx, bus.tx_busy, bus.tx_fifo_full});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({uart_tx, bus.tx_busy} !== 2'b10) begin
                errors++;
                $display("FAIL midrst_quiet cycle %0d: got tx/busy=%b expected 10", i, {uart_tx, bus.tx_busy});
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] v [2];
        logic       p [2];
        v[0] = 8'h07; p[0] = 1'b1;
        v[1] = 8'h03; p[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            bus.tx_wdata = v[n];
            bus.tx_wten  = 1'b1;
            @(negedge clk);
            drive_idle();
            @(negedge clk);
            for (int k = 0; k < FL; k++) begin
                @(negedge clk);
                rx[k] = uart_tx;
                checks++;
                if (uart_tx !== exp_bit(v[n], k)) begin
                    errors++;
                    $display("FAIL parity_frame %h sample %0d: got %b expected %b", v[n], k, uart_tx, exp_bit(v[n], k));
                end
            end
            checks++;
            if ({rx[9*B + B/2], bus.tx_busy} !== {p[n], 1'b0}) begin
                errors++;
                $display("FAIL parity_bit %h: got par/busy=%b%b expected %b0", v[n], rx[9*B + B/2], bus.tx_busy, p[n]);
            end
        end
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_overrun();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
